// File: rtl/clk_divisor_bank.sv
// clk_divisor_bank
// Bank of N_CH runtime-programmable clock dividers running off clk_in. Each
// channel produces a registered divided clock (clk_out) and a one-cycle strobe
// at its rising edge (tick). New ratios are taken through a valid/ready
// handshake into a per-channel shadow register. A channel switches to its new
// ratio only at its own period boundary, so no runt pulse is produced. sync_in
// restarts every channel in phase and applies any pending ratio at that point.
//
// Optional feature: define CLKDIV_FALL_TICK_EN to build per-channel fall_tick
// strobes that coincide with the clk_out high-to-low transition. If the macro
// is not defined, fall_tick is tied to zero.
module clk_divisor_bank #(
  parameter int N_CH        = 4,
  parameter int CH_W        = 2,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 36
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             sync_in,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  fall_tick
);

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_TWO = DIV_W'(2);

  logic [DIV_W-1:0] cnt_q    [N_CH];
  logic [DIV_W-1:0] cnt_d    [N_CH];
  logic [DIV_W-1:0] div_q    [N_CH];
  logic [DIV_W-1:0] div_d    [N_CH];
  logic [DIV_W-1:0] shadow_q [N_CH];
  logic [N_CH-1:0]  pending_q, pending_d;
  logic [N_CH-1:0]  clk_out_q, clk_out_d;
  logic [N_CH-1:0]  tick_q, tick_d;
  logic [N_CH-1:0]  active, wrap, apply, accept;

  // Ready follows the addressed channel's pending flag; unmapped indices are always ready
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    cfg_ready = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_ch == CH_W'(i) && pending_q[i]) cfg_ready = 1'b0;
    end
  end

  // Per-channel status: active ratio, end of period, ratio switch and handshake acceptance
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      active[i] = (div_q[i] >= DIV_TWO);
      wrap[i]   = (cnt_q[i] == div_q[i] - DIV_ONE);
      apply[i]  = pending_q[i] && (sync_in || (div_q[i] < DIV_TWO) ||
                                   (cnt_q[i] == div_q[i] - DIV_ONE));
      accept[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
    end
  end

  // Next state: sync beats wrap-apply beats normal counting; inactive channels stay at zero
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i]     = cnt_q[i];
      div_d[i]     = div_q[i];
      pending_d[i] = pending_q[i];
      clk_out_d[i] = 1'b0;
      tick_d[i]    = 1'b0;

      if (sync_in || !active[i]) begin
        cnt_d[i] = '0;
      end else begin
        clk_out_d[i] = (cnt_q[i] < (div_q[i] >> 1));
        tick_d[i]    = (cnt_q[i] == '0);
        cnt_d[i]     = wrap[i] ? '0 : cnt_q[i] + DIV_ONE;
      end

      // apply needs pending set and accept needs it clear, so the two never meet
      if (apply[i]) begin
        div_d[i]     = shadow_q[i];
        pending_d[i] = 1'b0;
      end
      if (accept[i]) pending_d[i] = 1'b1;
    end
  end

  // Counter, ratio, pending flag and output registers with synchronous active-low reset
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= DIV_RST;
      end
      pending_q <= '0;
      clk_out_q <= '0;
      tick_q    <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        div_q[i] <= div_d[i];
      end
      pending_q <= pending_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  // Shadow ratio capture on an accepted request
  always_ff @(posedge clk_in) begin
    // NOTE: shadow storage is deliberately not reset; its contents are read only while pending is set, and reset clears pending.
    for (int i = 0; i < N_CH; i++) begin
      if (accept[i]) shadow_q[i] <= cfg_div;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;

`ifdef CLKDIV_FALL_TICK_EN
  logic [N_CH-1:0] fall_q, fall_d;

  // Falling-edge strobe: fires when the counter reaches the half point (clk_out goes low)
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      fall_d[i] = !sync_in && active[i] && (cnt_q[i] == (div_q[i] >> 1));
    end
  end

  // Falling-edge strobe register
  always_ff @(posedge clk_in) begin
    if (!reset) fall_q <= '0;
    else        fall_q <= fall_d;
  end

  assign fall_tick = fall_q;
`else
  assign fall_tick = '0;
`endif

endmodule

// File: tb/tb_clk_divisor_bank.sv
// tb_clk_divisor_bank
// Directed bench for clk_divisor_bank (N_CH=4, DEFAULT_DIV=36). Inputs are
// driven and outputs sampled on the falling edge of clk_in. Expected values
// are hand-derived edge counts. Fall-tick expectations follow
// CLKDIV_FALL_TICK_EN.
module tb_clk_divisor_bank;

  localparam int N_CH  = 4;
  localparam int CH_W  = 2;
  localparam int DIV_W = 16;
`ifdef CLKDIV_FALL_TICK_EN
  localparam bit FALL_EN = 1'b1;
`else
  localparam bit FALL_EN = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             cfg_valid;
  logic             cfg_ready_w;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             sync_in;
  logic [N_CH-1:0]  clk_out_w;
  logic [N_CH-1:0]  tick_w;
  logic [N_CH-1:0]  fall_w;

  int n_chk = 0;
  int n_err = 0;
  int hi, per, n, t0, t1, hc, fall_pos, tick_pos;
  logic fall_seen = 1'b0;

  clk_divisor_bank #(
    .N_CH(N_CH), .CH_W(CH_W), .DIV_W(DIV_W), .DEFAULT_DIV(36)
  ) dut (
    .clk_in    (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready_w),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .sync_in   (sync_in),
    .clk_out   (clk_out_w),
    .tick      (tick_w),
    .fall_tick (fall_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset && (|fall_w)) fall_seen <= 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Start at a negedge where tick[ch] is high. Count the high samples and
  // the edges until the next tick. per stays -1 if no tick arrives in time.
  task automatic measure(input int ch, output int h, output int p);
    h = 0;
    p = -1;
    for (int k = 1; k <= 200; k++) begin
      if (clk_out_w[ch]) h++;
      @(negedge clk);
      if (tick_w[ch]) begin
        p = k;
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; sync_in = 1'b0;

    // Reset held for three edges
    repeat (3) @(negedge clk);
    check("rst_clk_out", clk_out_w, 4'h0);
    check("rst_tick", tick_w, 4'h0);
    check("rst_fall", fall_w, 4'h0);
    check("rst_ready", cfg_ready_w, 1'b1);
    reset = 1'b1;

    // E1: first edge after release gives tick and clk_out high on every channel
    @(negedge clk);
    check("first_tick", tick_w, 4'hF);
    check("first_clk_out", clk_out_w, 4'hF);
    measure(0, hi, per);
    check("ch0_default_high", hi, 18);
    check("ch0_default_period", per, 36);

    // ch1 div=5 mid-period (now at E37)
    repeat (10) @(negedge clk);
    cfg_ch = 2'd1; cfg_div = 16'd5; cfg_valid = 1'b1;
    check("ch1_ready_before", cfg_ready_w, 1'b1);
    @(negedge clk);
    cfg_valid = 1'b0;
    check("ch1_ready_drop", cfg_ready_w, 1'b0);
    n = 0; t0 = 0; hc = 0;
    while (!cfg_ready_w && n < 100) begin
      @(negedge clk);
      n++;
      if (tick_w[1]) t0++;
      if (clk_out_w[1]) hc++;
    end
    check("ch1_apply_wait", n, 24);
    check("ch1_old_ticks", t0, 0);
    check("ch1_old_high_tail", hc, 6);
    check("ch1_apply_edge_out", {tick_w[1], clk_out_w[1]}, 2'b00);
    @(negedge clk);
    check("ch1_new_tick", tick_w[1], 1'b1);
    measure(1, hi, per);
    check("ch1_div5_high", hi, 2);
    check("ch1_div5_period", per, 5);

    // ch2 div=1 (inactive), then div=8 (now at E78)
    cfg_ch = 2'd2; cfg_div = 16'd1; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    n = 0;
    while (!cfg_ready_w && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ch2_div1_apply_wait", n, 29);
    hc = 0;
    repeat (5) begin
      @(negedge clk);
      if (clk_out_w[2] || tick_w[2]) hc++;
    end
    check("ch2_inactive_quiet", hc, 0);
    check("ch2_inactive_ready", cfg_ready_w, 1'b1);
    cfg_div = 16'd8; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("ch2_div8_pending", cfg_ready_w, 1'b0);
    @(negedge clk);
    check("ch2_div8_applied", cfg_ready_w, 1'b1);
    check("ch2_apply_edge_out", {tick_w[2], clk_out_w[2]}, 2'b00);
    @(negedge clk);
    check("ch2_first_tick", tick_w[2], 1'b1);
    measure(2, hi, per);
    check("ch2_div8_high", hi, 4);
    check("ch2_div8_period", per, 8);

    // ch0 div=6, ch1 div=10, then a mid-phase sync (now at E124)
    cfg_ch = 2'd0; cfg_div = 16'd6; cfg_valid = 1'b1;
    check("ch0_ready", cfg_ready_w, 1'b1);
    @(negedge clk);
    cfg_ch = 2'd1; cfg_div = 16'd10;
    check("ch1_ready", cfg_ready_w, 1'b1);
    @(negedge clk);
    cfg_valid = 1'b0;
    check("ch1_pending_pre_sync", cfg_ready_w, 1'b0);
    sync_in = 1'b1;
    @(negedge clk);
    sync_in = 1'b0;
    check("sync_clk_out", clk_out_w, 4'h0);
    check("sync_tick", tick_w, 4'h0);
    check("sync_applied_pending", cfg_ready_w, 1'b1);
    @(negedge clk);
    check("post_sync_tick", tick_w, 4'hF);
    check("post_sync_clk_out", clk_out_w, 4'hF);
    n = 0; t0 = 0; t1 = 0;
    do begin
      @(negedge clk);
      n++;
      if (tick_w[0]) t0++;
      if (tick_w[1]) t1++;
    end while (!(tick_w[0] && tick_w[1]) && n < 100);
    check("coincide_period", n, 30);
    check("ch0_ticks_in_30", t0, 5);
    check("ch1_ticks_in_30", t1, 3);

    // Reset with ch3 pending div=12 (now at E158)
    cfg_ch = 2'd3; cfg_div = 16'd12; cfg_valid = 1'b1;
    check("ch3_ready", cfg_ready_w, 1'b1);
    @(negedge clk);
    cfg_valid = 1'b0;
    check("ch3_pending", cfg_ready_w, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_clk_out", clk_out_w, 4'h0);
    check("mid_rst_tick", tick_w, 4'h0);
    check("mid_rst_ready", cfg_ready_w, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("rerelease_tick", tick_w, 4'hF);
    measure(3, hi, per);
    check("ch3_default_high", hi, 18);
    check("ch3_default_period", per, 36);
    check("all_default_aligned", tick_w, 4'hF);
    check("ch3_ready_after", cfg_ready_w, 1'b1);

    // ch0 div=7 via sync; a cfg on the sync edge stays pending
    cfg_ch = 2'd0; cfg_div = 16'd7; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_ch = 2'd1; cfg_div = 16'd4;
    check("ch1_ready_at_sync", cfg_ready_w, 1'b1);
    sync_in = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; sync_in = 1'b0;
    check("cfg_on_sync_pending", cfg_ready_w, 1'b0);
    check("sync2_tick", tick_w, 4'h0);
    @(negedge clk);
    check("ch0_div7_tick", tick_w[0], 1'b1);
    fall_pos = 0; tick_pos = 0;
    for (int p = 1; p <= 20 && tick_pos == 0; p++) begin
      @(negedge clk);
      if (fall_w[0] && fall_pos == 0) fall_pos = p;
      if (tick_w[0]) tick_pos = p;
    end
    check("ch0_fall_pos", fall_pos, FALL_EN ? 3 : 0);
    check("ch0_div7_tick_pos", tick_pos, 7);
    measure(0, hi, per);
    check("ch0_div7_high", hi, 3);
    check("ch0_div7_period", per, 7);
    check("fall_seen", fall_seen, FALL_EN);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
